// File: rtl/sim_run_ctrl_if.sv
// Run-control bundle between sim_run_ctrl (master) and the core/testbench side (slave).
interface sim_run_ctrl_if #(
    parameter int unsigned CNT_W = 40
);
    logic             commit_valid;
    logic             halt_req;
    logic             core_rst;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] commits;

    modport master (
        input  commit_valid, halt_req,
        output core_rst, done, status, cycles, commits
    );

    modport slave (
        output commit_valid, halt_req,
        input  core_rst, done, status, cycles, commits
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: core reset sequencing, cycle/commit counting, halt/timeout/stall exit.
// Define SIM_RUN_CTRL_STALL_EN to compile in the commit-stall watchdog (status 11).
module sim_run_ctrl #(
    parameter int unsigned     CNT_W       = 40,
    parameter int unsigned     RST_CYCLES  = 5,
    parameter longint unsigned TIMEOUT     = 64'd1500000000,
    parameter int unsigned     STALL_LIMIT = 1000000,
    parameter int unsigned     HALT_DRAIN  = 16
) (
    input  logic           clk,
    input  logic           rst,
    sim_run_ctrl_if.master io_bus
);
    typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_STALL   = 2'b11;

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(HALT_DRAIN - 1);

    state_t           r_state;
    logic             r_core_rst;
    logic             r_done;
    logic [1:0]       r_status;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_commits;
    logic [CNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0] r_drain_cnt;

    logic [CNT_W-1:0] w_cycles_inc;
    logic [CNT_W-1:0] w_commits_inc;
    logic             w_timeout;
    logic             w_stall;

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign w_cycles_inc  = (&r_cycles) ? r_cycles : r_cycles + ONE;
    assign w_commits_inc = (io_bus.commit_valid && !(&r_commits)) ? r_commits + ONE : r_commits;
    assign w_timeout     = (TIMEOUT != 0) && (r_cycles == TIMEOUT_LAST);

`ifdef SIM_RUN_CTRL_STALL_EN
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

    logic [CNT_W-1:0] r_idle_cnt;

    assign w_stall = (r_idle_cnt == STALL_LAST) && !io_bus.commit_valid;

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_RUN) || io_bus.commit_valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + ONE;
        end
    end
`else
    // Watchdog compiled out; the term only keeps STALL_LIMIT referenced.
    assign w_stall = 1'b0 & (STALL_LIMIT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_status    <= ST_RUNNING;
            r_cycles    <= '0;
            r_commits   <= '0;
            r_rst_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state    <= S_RUN;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + ONE;
                    end
                end
                S_RUN: begin
                    r_cycles  <= w_cycles_inc;
                    r_commits <= w_commits_inc;
                    if (io_bus.halt_req) begin
                        if (HALT_DRAIN == 0) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_status <= ST_HALTED;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_status <= ST_TIMEOUT;
                    end else if (w_stall) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_status <= ST_STALL;
                    end
                end
                S_DRAIN: begin
                    r_cycles  <= w_cycles_inc;
                    r_commits <= w_commits_inc;
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_status <= ST_HALTED;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

    assign io_bus.core_rst = r_core_rst;
    assign io_bus.done     = r_done;
    assign io_bus.status   = r_status;
    assign io_bus.cycles   = r_cycles;
    assign io_bus.commits  = r_commits;
endmodule
